// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/acknowledge bundle for the two bus masters
// that share the memory through mem_arbiter.
interface mem_arbiter_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic              a_req;
  logic              a_we;
  logic [AWIDTH-1:0] a_addr;
  logic [DWIDTH-1:0] a_wdata;
  logic              a_ack;
  logic [DWIDTH-1:0] a_rdata;
  logic              b_req;
  logic              b_we;
  logic [AWIDTH-1:0] b_addr;
  logic [DWIDTH-1:0] b_wdata;
  logic              b_ack;
  logic [DWIDTH-1:0] b_rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_addr, b_wdata,
    input  b_ack, b_rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_addr, b_wdata,
    output b_ack, b_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises A/B requests onto a single-port memory.
// Define MEM_ARB_RR_EN for round-robin ties; default is fixed A priority.
module mem_arbiter #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      req_if,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  inout  wire  [DWIDTH-1:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_e;

  state_e            state_q, state_d;
  logic              sel_q, sel_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic [DWIDTH-1:0] a_rdata_q, a_rdata_d;
  logic [DWIDTH-1:0] b_rdata_q, b_rdata_d;

  logic              grant_b;
  logic              win_we;
  logic [AWIDTH-1:0] win_addr;
  logic [DWIDTH-1:0] win_wdata;

`ifdef MEM_ARB_RR_EN
  // last_q: 1 when B held the most recent grant
  logic last_q, last_d;

  // Tie goes to whichever requester was not granted last
  always_comb begin
    grant_b = req_if.b_req &
              (~req_if.a_req | ~last_q);
  end
`else
  // A wins every tie; B only when A is idle
  always_comb begin
    grant_b = req_if.b_req & ~req_if.a_req;
  end
`endif

  // Mux the winner's request fields
  always_comb begin
    win_we    = req_if.a_we;
    win_addr  = req_if.a_addr;
    win_wdata = req_if.a_wdata;
    if (grant_b) begin
      win_we    = req_if.b_we;
      win_addr  = req_if.b_addr;
      win_wdata = req_if.b_wdata;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
`ifdef MEM_ARB_RR_EN
    last_d    = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req_if.a_req | req_if.b_req) begin
          state_d = ACCESS;
          sel_d   = grant_b;
          wr_d    = win_we;
          rd_d    = ~win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
`ifdef MEM_ARB_RR_EN
          last_d  = grant_b;
`endif
        end
      end
      ACCESS: begin
        state_d = ACK;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        if (rd_q) begin
          if (sel_q) b_rdata_d = mem_data;
          else       a_rdata_d = mem_data;
        end
        if (sel_q) b_ack_d = 1'b1;
        else       a_ack_d = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign mem_rd         = rd_q;
  assign mem_wr         = wr_q;
  assign mem_addr       = addr_q;
  assign mem_data       = wr_q ? wdata_q : 'z;
  assign req_if.a_ack   = a_ack_q;
  assign req_if.b_ack   = b_ack_q;
  assign req_if.a_rdata = a_rdata_q;
  assign req_if.b_rdata = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, corner sequences and random traffic
// against a memory model and a transaction-level reference.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  logic [DW-1:0] tbmem  [32];
  logic [DW-1:0] refmem [32];
  logic [DW-1:0] last_rd [2];

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int last_win;
  int raise_cyc [2];
  logic          cur_we  [2];
  logic [AW-1:0] cur_addr[2];
  logic [DW-1:0] cur_wd  [2];
  bit            done    [2];

  typedef struct {
    int            p;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } vec_t;

  vec_t tbl [10];

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .req_if   (bus),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_data (mem_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory block: synchronous write, tri-state read, no reset
  always @(posedge clk) begin
    if (mem_wr) tbmem[mem_addr] <= mem_data;
  end
  assign mem_data = mem_rd ? tbmem[mem_addr] : 'z;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r,
                          input logic w,
                          input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd);
    if (p == 0) begin
      bus.a_req = r; bus.a_we = w;
      bus.a_addr = ad; bus.a_wdata = wd;
    end else begin
      bus.b_req = r; bus.b_we = w;
      bus.b_addr = ad; bus.b_wdata = wd;
    end
  endtask

  task automatic set_req(input int p, input logic r);
    if (p == 0) bus.a_req = r;
    else        bus.b_req = r;
  endtask

  function automatic logic get_ack(input int p);
    return (p == 0) ? bus.a_ack : bus.b_ack;
  endfunction

  function automatic logic get_req(input int p);
    return (p == 0) ? bus.a_req : bus.b_req;
  endfunction

  function automatic logic [DW-1:0] get_rd(input int p);
    return (p == 0) ? bus.a_rdata : bus.b_rdata;
  endfunction

  task automatic do_reset();
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", {31'b0, bus.a_ack}, 0);
    chk("rst_b_ack", {31'b0, bus.b_ack}, 0);
    chk("rst_a_rdata", {24'b0, bus.a_rdata}, 0);
    chk("rst_b_rdata", {24'b0, bus.b_rdata}, 0);
    chk("rst_mem_rd", {31'b0, mem_rd}, 0);
    chk("rst_mem_wr", {31'b0, mem_wr}, 0);
    chk("rst_mem_addr", {27'b0, mem_addr}, 0);
    last_rd[0] = '0;
    last_rd[1] = '0;
    last_win = 1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Entered just after a rising edge; leaves just after one
  task automatic do_txn(input int p, input logic we,
                        input logic [AW-1:0] ad,
                        input logic [DW-1:0] wd,
                        input logic [DW-1:0] er);
    int n, wrs, rds, oth, o;
    bit got;
    logic [AW-1:0] sa;
    o = 1 - p;
    n = 0; wrs = 0; rds = 0; oth = 0;
    got = 1'b0; sa = '0;
    set_port(p, 1'b1, we, ad, wd);
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_wr) wrs++;
      if (mem_rd) rds++;
      if (mem_wr || mem_rd) sa = mem_addr;
      if (get_ack(o)) oth++;
      if (get_ack(p)) got = 1'b1;
    end
    chk("txn_ack_latency", n, 3);
    chk("txn_wr_cycles", wrs, {31'b0, we});
    chk("txn_rd_cycles", rds, {31'b0, ~we});
    chk("txn_mem_addr", {27'b0, sa}, {27'b0, ad});
    chk("txn_other_ack", oth, 0);
    if (we) begin
      refmem[ad] = wd;
    end else begin
      chk("txn_rdata", {24'b0, get_rd(p)}, {24'b0, er});
      last_rd[p] = er;
    end
    chk("txn_other_rdata_held", {24'b0, get_rd(o)},
        {24'b0, last_rd[o]});
    @(posedge clk);
    #1;
    set_req(p, 1'b0);
  endtask

  task automatic req_proc(input int p);
    int gap, n;
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        set_req(p, 1'b0);
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
      cur_we[p]   = 1'($urandom_range(0, 1));
      cur_addr[p] = AW'($urandom_range(0, 7));
      cur_wd[p]   = DW'($urandom);
      set_port(p, 1'b1, cur_we[p], cur_addr[p], cur_wd[p]);
      raise_cyc[p] = cyc;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!get_ack(p) && n < 400);
      chk("rnd_ack_seen", {31'b0, get_ack(p)}, 1);
      @(posedge clk);
      #1;
    end
    set_req(p, 1'b0);
    done[p] = 1'b1;
  endtask

  // Transaction-level reference: arbitration rule plus memory contents
  task automatic rnd_check();
    int o, exp_w;
    bit tie;
    while (!(done[0] && done[1])) begin
      @(negedge clk);
      chk("rnd_single_ack",
          {31'b0, bus.a_ack & bus.b_ack}, 0);
      for (int p = 0; p < 2; p++) begin
        if (get_ack(p)) begin
          o = 1 - p;
          tie = get_req(o) && (raise_cyc[o] <= cyc - 2);
          if (tie) begin
`ifdef MEM_ARB_RR_EN
            exp_w = 1 - last_win;
`else
            exp_w = 0;
`endif
            chk("rnd_arb_winner", p, exp_w);
          end
          last_win = p;
          if (cur_we[p]) begin
            refmem[cur_addr[p]] = cur_wd[p];
          end else begin
            chk("rnd_rdata", {24'b0, get_rd(p)},
                {24'b0, refmem[cur_addr[p]]});
            last_rd[p] = refmem[cur_addr[p]];
          end
        end
      end
    end
  endtask

  // Bus protocol watch across every scenario
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("bus_rd_wr_excl", {31'b0, mem_rd & mem_wr}, 0);
        if (mem_rd)
          chk("bus_rd_data", {24'b0, mem_data},
              {24'b0, tbmem[mem_addr]});
      end
    end
  end

  initial begin
    int k, n, last_n, p, acks;
    int idx [2];
    int exp_ord [8];

    for (int i = 0; i < 32; i++) begin
      tbmem[i]  = '0;
      refmem[i] = '0;
    end
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    done[0] = 1'b0;
    done[1] = 1'b0;

    tbl[0] = '{0, 1'b1, 5'd5,  8'h3C, 8'h00};
    tbl[1] = '{0, 1'b0, 5'd5,  8'h00, 8'h3C};
    tbl[2] = '{1, 1'b1, 5'd31, 8'hFF, 8'h00};
    tbl[3] = '{1, 1'b0, 5'd31, 8'h00, 8'hFF};
    tbl[4] = '{0, 1'b1, 5'd0,  8'hA5, 8'h00};
    tbl[5] = '{1, 1'b0, 5'd0,  8'h00, 8'hA5};
    tbl[6] = '{0, 1'b0, 5'd31, 8'h00, 8'hFF};
    tbl[7] = '{1, 1'b1, 5'd5,  8'h5A, 8'h00};
    tbl[8] = '{0, 1'b0, 5'd5,  8'h00, 8'h5A};
    tbl[9] = '{1, 1'b0, 5'd1,  8'h00, 8'h00};

    do_reset();

    for (int i = 0; i < 10; i++)
      do_txn(tbl[i].p, tbl[i].we, tbl[i].addr,
             tbl[i].wdata, tbl[i].rdata);

    // Reset lands on the ACCESS cycle of an A write
    set_port(0, 1'b1, 1'b1, 5'd2, 8'h11);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_in_access", {31'b0, mem_wr}, 1);
    rst = 1'b1;
    refmem[2] = 8'h11;
    do_reset();
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(bus.a_ack) + int'(bus.b_ack);
    end
    chk("midrst_no_ack", acks, 0);
    @(posedge clk);
    #1;
    do_txn(0, 1'b0, 5'd2, 8'h00, 8'h11);

    // Continuous contention, 4 writes per port
    do_reset();
`ifdef MEM_ARB_RR_EN
    exp_ord = '{0, 1, 0, 1, 0, 1, 0, 1};
`else
    exp_ord = '{0, 0, 0, 0, 1, 1, 1, 1};
`endif
    idx[0] = 0;
    idx[1] = 0;
    set_port(0, 1'b1, 1'b1, 5'd10, 8'h40);
    set_port(1, 1'b1, 1'b1, 5'd20, 8'h80);
    k = 0; n = 0; last_n = 0;
    while (k < 8 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.a_ack || bus.b_ack) begin
        p = bus.b_ack ? 1 : 0;
        chk("cont_order", p, exp_ord[k]);
        if (k > 0) chk("cont_ack_gap", n - last_n, 3);
        last_n = n;
        k++;
        refmem[AW'((p ? 20 : 10) + idx[p])] =
          DW'((p ? 8'h80 : 8'h40) + idx[p]);
        @(posedge clk);
        #1;
        idx[p]++;
        if (idx[p] < 4)
          set_port(p, 1'b1, 1'b1,
                   AW'((p ? 20 : 10) + idx[p]),
                   DW'((p ? 8'h80 : 8'h40) + idx[p]));
        else
          set_req(p, 1'b0);
      end
    end
    chk("cont_count", k, 8);
    if (k < 8) begin
      @(posedge clk);
      #1;
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    do_txn(0, 1'b0, 5'd13, 8'h00, 8'h43);
    do_txn(1, 1'b0, 5'd23, 8'h00, 8'h83);

    // Random two-master traffic
    do_reset();
    fork
      req_proc(0);
      req_proc(1);
      rnd_check();
    join

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule
